mult_booth_seq: RTL and testbench
=================================

Name: mult_booth_seq

Overview:
- Iterative signed 32x32 multiplier for the MIPS execute stage. Implements MULT and produces the 64-bit HI/LO pair.
- Sits downstream of the 8-bit carry-lookahead adder slice and consumes its sums: one radix-2 Booth add/subtract per cycle, over 32 cycles.
- The ALU/control stage stalls on `busy` and writes HI/LO when `result_rdy` pulses.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clock      in   1   single clock, rising edge
- reset_n    in   1   asynchronous, active-low reset
- start      in   1   one-cycle request; operands sampled on the same edge
- operand_a  in   32  multiplicand, signed
- operand_b  in   32  multiplier, signed
- busy       out  1   high while iterating
- result_rdy out  1   one-cycle pulse: hi/lo are valid
- hi         out  32  product bits [63:32]
- lo         out  32  product bits [31:0]

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE. busy, result_rdy, hi, lo, count and all datapath registers are 0.
- States:
  - IDLE: start=1 → RUN.
  - RUN: count==31 at the edge → DONE.
  - DONE: always leaves after one cycle, to RUN if start=1, otherwise to IDLE.
- Start (in IDLE or DONE, start=1 at edge E0):
  - mcand ← sign-extended 33-bit operand_a.
  - acc ← 33'b0.
  - q ← operand_b.
  - q_1 ← 0.
  - count ← 0.
- Each RUN edge (E1..E32):
  - {q[0],q_1}=01: acc+mcand.
  - {q[0],q_1}=10: acc−mcand, computed as acc + ~mcand with carry-in 1.
  - 00 or 11: acc unchanged.
  - Then arithmetic right shift of {acc,q,q_1} by one, with acc[32] replicated. count increments.
- Adder width: 33 bits, so subtracting −2^31 never overflows the accumulator.
- Latency:
  - At E32, hi ← shifted acc[31:0] and lo ← shifted q, both registered together. State goes to DONE.
  - result_rdy=1 for exactly the cycle E32→E33, i.e. 32 cycles after the start edge.
- busy=1 from E0 to E32 inclusive, i.e. while state==RUN.
- hi and lo hold their value until the next completed operation. They do not change during RUN.
- start while RUN: ignored. Operands are not resampled and the count is unaffected.
- start during DONE: accepted back-to-back. result_rdy still pulses for the finishing operation.
- Reset mid-RUN: operation aborted, all outputs 0, no result_rdy pulse.
- operand_a and operand_b are don't-care except on the accepted start edge.

Optional Feature:
- Macro MULT_OVF_EN.
- Defined: adds output port `overflow` (out, 1 bit), registered with hi/lo at E32. overflow=1 iff hi ≠ {32{lo[31]}}, i.e. the product does not fit in signed 32 bits. Held until the next completion; reset value 0.
- Undefined: no port, no logic.

Decomposition:
- Shared package holds:
  - Constants MULT_WIDTH=32 and MULT_ITERS=32.
  - State encodings MS_IDLE=2'd0, MS_RUN=2'd1, MS_DONE=2'd2 (2'd3 decodes to IDLE).
  - Count width 5.
- One sub-module, addsub_33: 33-bit add/subtract with a sub control input. It is built from four cla_8 instances chained carry-to-carry, plus a 1-bit full-add slice for bit 32.
- The FSM, shift register and output registers stay in mult_booth_seq.

Test Plan:
- a=7, b=6, one start pulse → result_rdy exactly 32 cycles later; hi=0x00000000, lo=0x0000002A; busy high for the 32 RUN cycles.
- a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- a=b=0x80000000 → hi=0x40000000, lo=0x00000000. This exercises the 33-bit subtract of −2^31.
- a=0x7FFFFFFF, b=2 → hi=0x00000000, lo=0xFFFFFFFE. With MULT_OVF_EN, overflow=1. Then a=b=0xFFFFFFFF → lo=1, hi=0, overflow=0.
- Start 9×9; at cycle 10 pulse start with a=1, b=1 → ignored, result is lo=0x51. Back-to-back start in the DONE cycle (a=2, b=3) → second result_rdy 32 cycles later with lo=6, and hi/lo=0x51 held in between.
- Start 7×6; drop reset_n at cycle 15 for 2 cycles → busy=0, hi=lo=0, no result_rdy; a new start after release completes normally.

Source files
------------

// File: rtl/mult_booth_seq_pkg.sv
// Shared constants, state encoding and datapath structs for the sequential Booth multiplier.
package mult_booth_seq_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;
  localparam int MULT_CNT_W = 5;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  // {acc, q, q_1}: shifts right as one 66-bit arithmetic register
  typedef struct packed {
    logic [MULT_WIDTH:0]   acc;
    logic [MULT_WIDTH-1:0] q;
    logic                  q_1;
  } booth_t;

  typedef struct packed {
    logic [MULT_WIDTH-1:0] hi;
    logic [MULT_WIDTH-1:0] lo;
  } mult_rsp_t;

  function automatic logic [MULT_WIDTH:0] sext1(input logic [MULT_WIDTH-1:0] v);
    return {v[MULT_WIDTH-1], v};
  endfunction
endpackage

// File: rtl/mult_booth_seq_addsub_33.sv
// 33-bit add/subtract: four chained 8-bit carry-lookahead slices plus a 1-bit top slice.
module cla_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;
  logic       t, pp;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    t = 1'b0;
    pp = 1'b0;
    c[0] = cin;
    // each carry is the flat generate/propagate sum, not a ripple chain
    for (int i = 0; i < 8; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & cin);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module addsub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);
  logic [32:0] bx;
  logic [4:0]  c;

  // subtract as a + ~b + 1
  assign bx   = b ^ {33{sub}};
  assign c[0] = sub;

  for (genvar k = 0; k < 4; k++) begin : g_slice
    cla_8 u_cla (
      .a   (a[8*k +: 8]),
      .b   (bx[8*k +: 8]),
      .cin (c[k]),
      .sum (sum[8*k +: 8]),
      .cout(c[k+1])
    );
  end

  assign sum[32] = a[32] ^ bx[32] ^ c[4];
endmodule

// File: rtl/mult_booth_seq.sv
// Radix-2 Booth signed 32x32 multiplier, one add/sub per cycle, 32 iterations to HI/LO.
// Define MULT_OVF_EN to add the registered 'overflow' output (product exceeds signed 32 bits).
import mult_booth_seq_pkg::*;

module mult_booth_seq #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             result_rdy,
`ifdef MULT_OVF_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  ms_state_e             state, state_nx;
  booth_t                bq, bq_nx;
  mult_rsp_t             rsp;
  logic [MULT_WIDTH:0]   mcand, sum, acc_op;
  logic [MULT_CNT_W-1:0] count;
  logic                  accept, last, sub;

  assign accept = start && (state != MS_RUN);
  assign last   = (state == MS_RUN) && (count == MULT_CNT_W'(MULT_ITERS - 1));
  assign sub    = bq.q[0] & ~bq.q_1;

  addsub_33 u_addsub (
    .a  (bq.acc),
    .b  (mcand),
    .sub(sub),
    .sum(sum)
  );

  always_comb begin
    acc_op = (bq.q[0] ^ bq.q_1) ? sum : bq.acc;
    bq_nx  = {acc_op[MULT_WIDTH], acc_op, bq.q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= MS_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = MS_IDLE;
    case (state)
      MS_IDLE: state_nx = start ? MS_RUN : MS_IDLE;
      MS_RUN:  state_nx = last  ? MS_DONE : MS_RUN;
      MS_DONE: state_nx = start ? MS_RUN : MS_IDLE;
      default: state_nx = MS_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == MS_RUN);
    result_rdy = (state == MS_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand <= '0;
      bq    <= '0;
      count <= '0;
      rsp   <= '0;
    end else if (accept) begin
      mcand <= sext1(operand_a);
      bq    <= {{(MULT_WIDTH+1){1'b0}}, operand_b, 1'b0};
      count <= '0;
    end else if (state == MS_RUN) begin
      bq    <= bq_nx;
      count <= count + 1'b1;
      if (last) rsp <= {bq_nx.acc[MULT_WIDTH-1:0], bq_nx.q};
    end
  end

  assign hi = rsp.hi;
  assign lo = rsp.lo;

`ifdef MULT_OVF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  overflow <= 1'b0;
    else if (last) overflow <= bq_nx.acc[MULT_WIDTH-1:0] != {MULT_WIDTH{bq_nx.q[MULT_WIDTH-1]}};
  end
`endif
endmodule

// File: tb/tb_mult_booth_seq.sv
// Scoreboard bench for mult_booth_seq: products, latency, ignored/back-to-back start, reset abort.
module tb_mult_booth_seq;
  logic        clock = 1'b0;
  logic        reset_n, start, busy, result_rdy;
  logic [31:0] operand_a, operand_b, hi, lo;
`ifdef MULT_OVF_EN
  logic        overflow;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0, busy_cnt = 0;

  mult_booth_seq dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .result_rdy(result_rdy),
`ifdef MULT_OVF_EN
    .overflow  (overflow),
`endif
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // called just after a negedge; start is seen by the following posedge
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit push);
    longint pa, pb, pr;
    exp_t   e;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    pr = pa * pb;
    e.hi  = pr[63:32];
    e.lo  = pr[31:0];
    e.ovf = (pr[63:32] != {32{pr[31]}});
    e.due = cyc + 33;
    start = 1'b1;
    operand_a = a;
    operand_b = b;
    if (push) sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      @(negedge clock);
      #1;
    end
    chk("timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (result_rdy) begin
      if (sb.size() == 0) chk("spurious_rdy", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("latency", 64'(cyc), 64'(e.due));
`ifdef MULT_OVF_EN
        chk("ovf", 64'(overflow), 64'(e.ovf));
`endif
      end
    end
  end

  logic [31:0] va[9] = '{32'hFFFFFFFD, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                         32'h00000000, 32'h80000000, 32'h12345678, 32'hDEADBEEF, 32'h00000001};
  logic [31:0] vb[9] = '{32'h00000005, 32'h80000000, 32'h00000002, 32'hFFFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h9ABCDEF0, 32'hCAFEBABE, 32'h80000000};

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(result_rdy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
`ifdef MULT_OVF_EN
    chk("rst_ovf", 64'(overflow), 64'd0);
`endif
    reset_n = 1'b1;

    @(negedge clock);
    busy_cnt = 0;
    drive_start(32'd7, 32'd6, 1'b1);
    wait_idle();
    chk("busy_cycles", 64'(busy_cnt), 64'd32);

    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      drive_start(va[i], vb[i], 1'b1);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive_start($urandom, $urandom, 1'b1);
      wait_idle();
    end

    // start while running is ignored; start in DONE chains a new op
    @(negedge clock);
    drive_start(32'd9, 32'd9, 1'b1);
    repeat (8) @(negedge clock);
    drive_start(32'd1, 32'd1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (result_rdy) break;
    end
    chk("rdy_seen", 64'(result_rdy), 64'd1);
    drive_start(32'd2, 32'd3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      chk("hold", {hi, lo}, {32'd0, 32'h51});
      @(negedge clock);
    end
    wait_idle();

    // reset mid-run aborts the op
    @(negedge clock);
    drive_start(32'd7, 32'd6, 1'b1);
    repeat (13) @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rdy", 64'(result_rdy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    drive_start(32'd7, 32'd6, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
